axi4_read_router: RTL

Single-master AXI4 read-channel router for the crossbar test harness. It accepts one AR transaction at a time from the master, decodes the address into a one-hot slave select, and forwards AR to the selected RAM slave. It then passes that slave's R beats back to the master. Unmapped addresses are answered locally with a full-length DECERR burst. The block sits directly downstream of the crossbar's ADDRESS_CHECK decoder, which it instantiates, and feeds four RAM slave ports.

---
 rtl/axi4_read_router_if.sv | 74 +++++++
 rtl/axi4_read_router.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_router_if.sv
// ---------------------------------------------------------------------------
// axi4_read_router_if
//
// Bundles every bus signal of the single-master AXI4 read router: the
// upstream master AR/R channels (m_*) and the four downstream RAM slave
// ports (s_*). The slave-side vectors are packed so that bit k / slice k
// belongs to slave port k (bit 3 = RAM1 ... bit 0 = RAM4).
//
// Modports:
//   slave  - the router itself: receives master AR, drives master R,
//            drives the broadcast slave AR and per-slave R ready.
//   master - the surrounding environment: the upstream master together
//            with the four RAM slaves (drives everything the router reads).
// ---------------------------------------------------------------------------
interface axi4_read_router_if #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
);
    // Upstream master AR channel
    logic [ID_WIDTH-1:0]     m_arid;
    logic [31:0]             m_araddr;
    logic [7:0]              m_arlen;
    logic [2:0]              m_arsize;
    logic [1:0]              m_arburst;
    logic                    m_arvalid;
    logic                    m_arready;

    // Upstream master R channel
    logic [ID_WIDTH-1:0]     m_rid;
    logic [DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]              m_rresp;
    logic                    m_rlast;
    logic                    m_rvalid;
    logic                    m_rready;

    // Downstream AR channel, payload broadcast to all four slaves
    logic [ID_WIDTH-1:0]     s_arid;
    logic [31:0]             s_araddr;
    logic [7:0]              s_arlen;
    logic [2:0]              s_arsize;
    logic [1:0]              s_arburst;
    logic [3:0]              s_arvalid;
    logic [3:0]              s_arready;

    // Downstream R channels, packed per slave
    logic [4*ID_WIDTH-1:0]   s_rid;
    logic [4*DATA_WIDTH-1:0] s_rdata;
    logic [7:0]              s_rresp;
    logic [3:0]              s_rlast;
    logic [3:0]              s_rvalid;
    logic [3:0]              s_rready;

    modport slave (
        input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        output m_arready,
        output m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        input  m_rready,
        output s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        input  s_arready,
        input  s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        output s_rready
    );

    modport master (
        output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid,
        input  m_arready,
        input  m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
        output m_rready,
        input  s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arvalid,
        output s_arready,
        output s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
        input  s_rready
    );
endinterface

// File: rtl/axi4_read_router.sv
// ---------------------------------------------------------------------------
// axi4_read_router
//
// Single-master AXI4 read-channel router. One AR transaction is accepted at
// a time, its address is decoded into a one-hot slave select by
// ADDRESS_CHECK, and the AR is forwarded to the selected RAM slave. That
// slave's R beats are then passed straight through to the master. Addresses
// outside the four RAM windows are answered locally with a full-length
// DECERR burst.
//
// Ports:
//   ACLK    - clock, all logic on the rising edge
//   ARESET  - synchronous active-high reset
//   bus     - axi4_read_router_if.slave: master AR/R channels plus the four
//             downstream RAM slave AR/R channels (bit 3 = RAM1 ... bit 0 = RAM4)
//
// Parameters:
//   ID_WIDTH, DATA_WIDTH - must match the widths of the connected interface
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// ADDRESS_CHECK
//
// Address decoder shared with the crossbar. Produces a one-hot slave select
// for the four 4 KiB RAM windows starting at address 0, or all zeros when
// the address is unmapped or valid is low.
//
// Ports:
//   valid  - qualifies the address
//   addr   - 32-bit byte address
//   select - one-hot select, bit 3 = [0x0000,0x1000) ... bit 0 = [0x3000,0x4000)
// ---------------------------------------------------------------------------
module ADDRESS_CHECK (
    input  logic        valid,
    input  logic [31:0] addr,
    output logic [3:0]  select
);
    // Only the lowest 16 KiB is mapped; bits [13:12] pick the 4 KiB window.
    always_comb begin
        select = 4'b0000;
        if (valid && (addr[31:14] == 18'd0)) begin
            case (addr[13:12])
                2'd0:    select = 4'b1000;
                2'd1:    select = 4'b0100;
                2'd2:    select = 4'b0010;
                default: select = 4'b0001;
            endcase
        end
    end
endmodule

module axi4_read_router #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic               ACLK,
    input  logic               ARESET,
    axi4_read_router_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] FWD_AR = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] ERR    = 2'd3;

    logic [1:0]            state;

    logic [ID_WIDTH-1:0]   arid_q;
    logic [31:0]           araddr_q;
    logic [7:0]            arlen_q;
    logic [2:0]            arsize_q;
    logic [1:0]            arburst_q;
    logic [3:0]            sel_q;
    logic [7:0]            beat_cnt;

    logic [3:0]            dec_sel;

    logic                  sel_arready;
    logic                  sel_rvalid;
    logic                  sel_rlast;
    logic [ID_WIDTH-1:0]   sel_rid;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic [1:0]            sel_rresp;

    // Decode is qualified by m_arvalid so an idle bus never produces a select.
    ADDRESS_CHECK u_address_check (
        .valid  (bus.m_arvalid),
        .addr   (bus.m_araddr),
        .select (dec_sel)
    );

    // The slave AR handshake only counts on the selected port; ready from
    // the other slaves is masked off.
    assign sel_arready = |(bus.s_arready & sel_q);

    // Pick the selected slave's R slice. sel_q is one-hot, so at most one
    // iteration matches and the others leave the defaults untouched.
    always_comb begin
        sel_rvalid = 1'b0;
        sel_rlast  = 1'b0;
        sel_rid    = '0;
        sel_rdata  = '0;
        sel_rresp  = '0;
        for (int k = 0; k < 4; k++) begin
            if (sel_q[k]) begin
                sel_rvalid = bus.s_rvalid[k];
                sel_rlast  = bus.s_rlast[k];
                sel_rid    = bus.s_rid[k*ID_WIDTH +: ID_WIDTH];
                sel_rdata  = bus.s_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                sel_rresp  = bus.s_rresp[2*k +: 2];
            end
        end
    end

    // Transaction sequencer. IDLE captures the AR and select; mapped
    // addresses go through FWD_AR then DATA, unmapped ones go straight to
    // ERR, which counts down the local DECERR beats from the captured ARLEN.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state     <= IDLE;
            arid_q    <= '0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            arsize_q  <= '0;
            arburst_q <= '0;
            sel_q     <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_arvalid) begin
                        arid_q    <= bus.m_arid;
                        araddr_q  <= bus.m_araddr;
                        arlen_q   <= bus.m_arlen;
                        arsize_q  <= bus.m_arsize;
                        arburst_q <= bus.m_arburst;
                        sel_q     <= dec_sel;
                        beat_cnt  <= bus.m_arlen;
                        state     <= (dec_sel != 4'b0000) ? FWD_AR : ERR;
                    end
                end
                FWD_AR: begin
                    if (sel_arready) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sel_rvalid && bus.m_rready && sel_rlast) begin
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (bus.m_rready) begin
                        if (beat_cnt == 8'd0) begin
                            state <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt - 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The AR payload seen by the slaves is the captured copy, so it stays
    // stable for as long as the selected slave withholds s_arready.
    assign bus.s_arid    = arid_q;
    assign bus.s_araddr  = araddr_q;
    assign bus.s_arlen   = arlen_q;
    assign bus.s_arsize  = arsize_q;
    assign bus.s_arburst = arburst_q;

    // Handshake outputs are forced low while ARESET is high so that no AR
    // is accepted and no R beat completes on the reset edge of an
    // abandoned transaction.
    assign bus.m_arready = (state == IDLE) && !ARESET;
    assign bus.s_arvalid = ((state == FWD_AR) && !ARESET) ? sel_q : 4'b0000;
    assign bus.s_rready  = ((state == DATA) && !ARESET && bus.m_rready) ? sel_q : 4'b0000;

    // Master R channel: zero-latency pass-through in DATA, locally generated
    // DECERR beats in ERR (held stable by the registers during stalls),
    // quiet otherwise.
    always_comb begin
        bus.m_rvalid = 1'b0;
        bus.m_rid    = '0;
        bus.m_rdata  = '0;
        bus.m_rresp  = 2'b00;
        bus.m_rlast  = 1'b0;
        if (!ARESET) begin
            case (state)
                DATA: begin
                    bus.m_rvalid = sel_rvalid;
                    bus.m_rid    = sel_rid;
                    bus.m_rdata  = sel_rdata;
                    bus.m_rresp  = sel_rresp;
                    bus.m_rlast  = sel_rlast;
                end
                ERR: begin
                    bus.m_rvalid = 1'b1;
                    bus.m_rid    = arid_q;
                    bus.m_rdata  = '0;
                    bus.m_rresp  = 2'b11;
                    bus.m_rlast  = (beat_cnt == 8'd0);
                end
                default: begin
                end
            endcase
        end
    end
endmodule
